// File: rtl/cdb_arbiter_pkg.sv
// cdb_arbiter_pkg: shared CDB constants (tag/data widths, idle tag) and index-width helper.
`ifndef CDB_DEFINES
`define CDB_DEFINES
`define Reg_Lock_Width 5
`define Data_Width 32
`define Reg_No_Lock 5'd0
`define Cdb_Units 4
`endif

package cdb_arbiter_pkg;
    localparam int DEF_UNITS = `Cdb_Units;
    localparam int DEF_LOCK_W = `Reg_Lock_Width;
    localparam int DEF_DATA_W = `Data_Width;
    localparam logic [DEF_LOCK_W-1:0] DEF_NO_LOCK = `Reg_No_Lock;
    function automatic int idx_w(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/cdb_arbiter_rr_picker.sv
// rr_picker: combinational round-robin select, first set bit of eff scanning upward from rr_ptr.
module rr_picker #(
    parameter int N = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  eff,
    input  logic [IW-1:0] rr_ptr,
    output logic [IW-1:0] winner,
    output logic          any
);
    always_comb begin
        winner = '0;
        for (int k = N - 1; k >= 0; k--) begin
            int j;
            j = (int'(rr_ptr) + k) % N;
            if (eff[IW'(j)]) winner = IW'(j);
        end
    end
    assign any = |eff;
endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin common-data-bus responder with registered broadcast and one-hot done.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int NUM_UNITS = DEF_UNITS,
    parameter int LOCK_W = DEF_LOCK_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter logic [LOCK_W-1:0] NO_LOCK = LOCK_W'(DEF_NO_LOCK)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_UNITS-1:0]        req_valid,
    input  logic [NUM_UNITS*LOCK_W-1:0] req_index,
    input  logic [NUM_UNITS*DATA_W-1:0] req_result,
    output logic [NUM_UNITS-1:0]        done,
    output logic                        cdb_valid,
    output logic [LOCK_W-1:0]           cdb_index,
    output logic [DATA_W-1:0]           cdb_result,
    output logic [15:0]                 bcast_count
);
    localparam int IW = idx_w(NUM_UNITS);
    logic [IW-1:0] rr_ptr, winner;
    logic any, dest;
    logic [NUM_UNITS-1:0] eff;
    logic [LOCK_W-1:0] win_index;
    logic [DATA_W-1:0] win_result;
    // The registered done is the mask: the acknowledged unit still shows its old valid this cycle.
    assign eff = req_valid & ~done;
    assign win_index = req_index[winner*LOCK_W +: LOCK_W];
    assign win_result = req_result[winner*DATA_W +: DATA_W];
    assign dest = any && win_index != NO_LOCK;
    rr_picker #(.N(NUM_UNITS), .IW(IW)) picker (
        .eff(eff),
        .rr_ptr(rr_ptr),
        .winner(winner),
        .any(any)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            done <= '0;
            cdb_valid <= 1'b0;
            cdb_index <= NO_LOCK;
            cdb_result <= '0;
            bcast_count <= '0;
            rr_ptr <= '0;
        end else begin
            done <= any ? NUM_UNITS'(1) << winner : '0;
            cdb_valid <= dest;
            cdb_index <= dest ? win_index : NO_LOCK;
            if (dest) begin
                cdb_result <= win_result;
                bcast_count <= bcast_count + 16'd1;
            end
            if (any) rr_ptr <= int'(winner) == NUM_UNITS - 1 ? '0 : winner + 1'b1;
        end
    end
endmodule
